xnor_popcnt_acc: RTL and testbench
==================================

# xnor_popcnt_acc

Parametrised, registered successor to the single-bit XNOR gate: a WIDTH-bit bitwise XNOR whose matching-bit count (popcount) is accumulated over BEATS input vectors, giving a binary similarity score (XNOR-popcount dot product). Operand vectors arrive on a valid/ready input stream, and one result per BEATS accepted vectors leaves on a valid/ready output stream. The block sits between an operand source (register file or FIFO) and any consumer of match scores.

## Interface
- WIDTH, 8, operand width in bits (≥1)
- BEATS, 4, vectors accumulated per result (≥1)
- ACC_W, $clog2(WIDTH*BEATS+1), result width (derived localparam, not overridable)
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  a/b valid this cycle
- in_ready  output  1  block accepts a/b this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  y/all_match valid
- out_ready  input  1  consumer accepts result
- y  output  ACC_W  total matching bits over BEATS vectors (0..WIDTH*BEATS)
- all_match  output  1  1 when y == WIDTH*BEATS

## Operation
- Per-beat term: pc = popcount(~(a ^ b)), range 0..WIDTH, zero-extended to ACC_W.
- Input handshake: beat accepted iff in_valid && in_ready on a rising edge; a/b ignored otherwise.
- FSM, two states:
  - ACCUM: in_ready=1, out_valid=0. On accept with beat_cnt < BEATS-1: acc += pc, beat_cnt++. On accept with beat_cnt == BEATS-1: y <= acc+pc, all_match <= (acc+pc == WIDTH*BEATS), acc <= 0, beat_cnt <= 0, go HOLD.
  - HOLD: in_ready=0, out_valid=1, y/all_match stable. On out_ready=1: go ACCUM. If out_ready=0, stay (unbounded backpressure).
- in_valid gaps in ACCUM: no state change; partial sum retained.
- in_valid asserted while in HOLD: not accepted, no effect.
- BEATS=1: every accepted vector produces a result.
- Arithmetic never overflows: ACC_W covers WIDTH*BEATS exactly.
- rst (any state, including mid-accumulation or during HOLD): state=ACCUM, acc=0, beat_cnt=0, y=0, all_match=0, out_valid=0; partial sum discarded. rst has priority over every handshake in the same cycle.

## Timing
- Reset values: in_ready=1, out_valid=0, y=0, all_match=0.
- Latency: out_valid rises on the edge that accepts the final beat (visible the cycle after the final beat is presented).
- out_valid falls on the edge where out_valid && out_ready; in_ready rises the same edge.
- Throughput: at most one result every BEATS+1 cycles (one HOLD cycle minimum).
- in_ready and out_valid are pure functions of state, with no combinational path from in_valid or out_ready.
- y/all_match change only on entry to HOLD or on reset.

## Structure
- Shared package coa_pkg: FSM state encoding (ST_ACCUM, ST_HOLD) as localparams/typedef; reused by later handshake blocks.
- Sub-module popcount (combinational, parameter WIDTH, in[WIDTH-1:0] -> out[$clog2(WIDTH+1)-1:0]), instantiated once on ~(a^b).
- Top: FSM, acc, beat_cnt ($clog2(BEATS) bits, min 1), output registers.

## Test plan
All with WIDTH=8, BEATS=4.
- Reset: hold rst 2 cycles -> in_ready=1, out_valid=0, y=0, all_match=0.
- a=b=8'hA5 for 4 consecutive beats, out_ready=1 -> out_valid one cycle after 4th accept, y=32, all_match=1, out_valid high exactly one cycle.
- a=8'h00, b=8'hFF ×4 -> y=0, all_match=0.
- Beats (F0,FF),(AA,55),(0F,0F),(81,80) with in_valid low 2 cycles between beats 2 and 3 -> y=4+0+8+7=19, all_match=0.
- Backpressure: after a result, out_ready=0 for 5 cycles while in_valid=1 with a=b=0 -> y stays 19, in_ready=0, no beats consumed; out_ready=1 -> next cycle out_valid=0, in_ready=1, following 4 beats of a=b=FF give y=32.
- Reset mid-op: accept 2 beats of (00,FF), assert rst 1 cycle, then 4 beats of a=b=3C -> y=32 (partial sum discarded).

Source files
------------

// File: rtl/coa_pkg.sv
// Shared handshake-block definitions: the accumulate/hold state encoding
// reused by the valid/ready stream blocks in this slice.
package coa_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } coa_state_t;

endpackage

// File: rtl/xnor_popcnt_acc_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module popcount #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]           in,
  output logic [$clog2(WIDTH+1)-1:0] out
);

  localparam int OW = $clog2(WIDTH + 1);

  always_comb begin
    out = '0;
    for (int i = 0; i < WIDTH; i++) begin
      out = out + OW'(in[i]);
    end
  end

endmodule

// File: rtl/xnor_popcnt_acc.sv
// XNOR-popcount similarity: accumulates matching-bit counts over BEATS
// accepted vectors and presents one score per group on a valid/ready stream.
module xnor_popcnt_acc
  import coa_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BEATS = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [WIDTH-1:0]                     a,
  input  logic [WIDTH-1:0]                     b,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [$clog2(WIDTH*BEATS+1)-1:0]     y,
  output logic                                 all_match
);

  localparam int ACC_W = $clog2(WIDTH * BEATS + 1);
  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ACC_W-1:0] FULL_SCORE = ACC_W'(WIDTH * BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BEATS - 1);

  coa_state_t       state;
  coa_state_t       state_next;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] beat_cnt;
  logic [PC_W-1:0]  pc;
  logic [ACC_W-1:0] sum;
  logic             accept;
  logic             last_beat;

  popcount #(.WIDTH(WIDTH)) u_popcount (
    .in  (~(a ^ b)),
    .out (pc)
  );

  // Handshake flags depend only on state, never on in_valid/out_ready.
  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_HOLD);
  assign accept    = in_valid && in_ready;
  assign last_beat = (beat_cnt == LAST_BEAT);
  assign sum       = acc + ACC_W'(pc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ACCUM;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_ACCUM: if (accept && last_beat) state_next = ST_HOLD;
      ST_HOLD:  if (out_ready)           state_next = ST_ACCUM;
      default:                           state_next = ST_ACCUM;
    endcase
  end

  // The score registers only load on the final beat, so they stay stable in HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      beat_cnt  <= '0;
      y         <= '0;
      all_match <= 1'b0;
    end else if (accept) begin
      if (last_beat) begin
        y         <= sum;
        all_match <= (sum == FULL_SCORE);
        acc       <= '0;
        beat_cnt  <= '0;
      end else begin
        acc      <= sum;
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_xnor_popcnt_acc.sv
// Directed bench for xnor_popcnt_acc: a transaction-level score model checked
// every cycle, plus literal expected scores for each directed scenario.
module tb_xnor_popcnt_acc;

  localparam int WIDTH = 8;
  localparam int BEATS = 4;
  localparam int ACC_W = $clog2(WIDTH * BEATS + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] y;
  logic             all_match;

  int checks = 0;
  int errors = 0;

  // Score model: list of matching-bit counts for the current group.
  int  m_terms[$];
  bit  m_hold    = 1'b0;
  int  m_y       = 0;
  bit  m_all     = 1'b0;
  bit  m_started = 1'b0;

  xnor_popcnt_acc #(.WIDTH(WIDTH), .BEATS(BEATS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .all_match (all_match)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      m_terms.delete();
      m_hold    = 1'b0;
      m_y       = 0;
      m_all     = 1'b0;
      m_started = 1'b1;
    end else if (!m_hold) begin
      if (in_valid) begin
        m_terms.push_back($countones(~(a ^ b)));
        if (m_terms.size() == BEATS) begin
          m_y = 0;
          foreach (m_terms[i]) m_y += m_terms[i];
          m_all  = (m_y == WIDTH * BEATS);
          m_hold = 1'b1;
          m_terms.delete();
        end
      end
    end else if (out_ready) begin
      m_hold = 1'b0;
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_started) begin
      check_output("model_in_ready",  int'(in_ready),  int'(!m_hold));
      check_output("model_out_valid", int'(out_valid), int'(m_hold));
      check_output("model_y",         int'(y),         m_y);
      check_output("model_all_match", int'(all_match), int'(m_all));
    end
  end

  task automatic apply_stimulus(input logic v, input logic [WIDTH-1:0] av,
                                input logic [WIDTH-1:0] bv, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    a         = av;
    b         = bv;
    out_ready = ordy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, '0, out_ready);
  endtask

  // Waits (bounded) for out_valid then checks the score against literals.
  task automatic expect_result(input string name, input int exp_y, input bit exp_all);
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_output({name, "_latency"}, waited, 0);
    check_output({name, "_y"}, int'(y), exp_y);
    check_output({name, "_all_match"}, int'(all_match), int'(exp_all));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset for two cycles.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_output("reset_in_ready",  int'(in_ready),  1);
    check_output("reset_out_valid", int'(out_valid), 0);
    check_output("reset_y",         int'(y),         0);
    check_output("reset_all_match", int'(all_match), 0);
    rst = 1'b0;

    // All bits match on every beat.
    for (int i = 0; i < BEATS; i++) apply_stimulus(1'b1, 8'hA5, 8'hA5, 1'b1);
    expect_result("all_equal", 32, 1'b1);
    @(negedge clk);
    check_output("all_equal_one_cycle_valid", int'(out_valid), 0);

    // No bits match.
    for (int i = 0; i < BEATS; i++) apply_stimulus(1'b1, 8'h00, 8'hFF, 1'b1);
    expect_result("all_differ", 0, 1'b0);
    @(negedge clk);

    // Mixed beats with a two-cycle input gap; hold the result with backpressure.
    apply_stimulus(1'b1, 8'hF0, 8'hFF, 1'b0);
    apply_stimulus(1'b1, 8'hAA, 8'h55, 1'b0);
    idle(2);
    apply_stimulus(1'b1, 8'h0F, 8'h0F, 1'b0);
    apply_stimulus(1'b1, 8'h81, 8'h80, 1'b0);
    expect_result("gapped", 19, 1'b0);

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 8'h00, 8'h00, 1'b0);
      check_output("backpressure_y",        int'(y),         19);
      check_output("backpressure_in_ready", int'(in_ready),  0);
      check_output("backpressure_valid",    int'(out_valid), 1);
    end
    apply_stimulus(1'b0, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    check_output("release_out_valid", int'(out_valid), 0);
    check_output("release_in_ready",  int'(in_ready),  1);
    in_valid = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    for (int i = 1; i < BEATS; i++) apply_stimulus(1'b1, 8'hFF, 8'hFF, 1'b1);
    expect_result("after_backpressure", 32, 1'b1);
    @(negedge clk);

    // Reset in the middle of a group discards the partial sum.
    apply_stimulus(1'b1, 8'h00, 8'hFF, 1'b1);
    apply_stimulus(1'b1, 8'h00, 8'hFF, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    rst      = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check_output("midreset_y",         int'(y),         0);
    check_output("midreset_out_valid", int'(out_valid), 0);
    for (int i = 0; i < BEATS; i++) apply_stimulus(1'b1, 8'h3C, 8'h3C, 1'b1);
    expect_result("after_midreset", 32, 1'b1);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
